// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller.
//   - request size encodings (byte/half/word; 3 is illegal)
//   - FSM state type
//   - big-endian lane helpers used by the controller and the lane aligner
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a request, req_ready high
    ST_RD   = 2'd1,  // word store write, or read of the target word
    ST_MRG  = 2'd2,  // old word on ram_q: extract a load or write a merged store
    ST_RESP = 2'd3   // response held until rsp_ready
  } state_e;

  // Right-shift that brings the addressed lane down to bit 0 of the word.
  // Big-endian: the lowest byte offset lives in the most significant lane,
  // so the shift is (bytes to the right of the lane) * 8.
  function automatic logic [4:0] lane_shift(input logic [1:0] offset,
                                            input logic [1:0] size);
    logic [4:0] shift;
    case (size)
      SIZE_BYTE: shift = {~offset, 3'b000};
      SIZE_HALF: shift = {~offset[1], 4'b0000};
      default:   shift = 5'd0;
    endcase
    return shift;
  endfunction

  // Size 3, odd halfword or unaligned word address.
  function automatic logic is_illegal(input logic [1:0] size,
                                      input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational big-endian lane aligner.
// Ports:
//   word_i   - word currently held in RAM (ram_q during the merge cycle)
//   offset_i - byte offset within the word (addr[1:0])
//   size_i   - byte / half / word
//   uns_i    - zero-extend instead of sign-extend sub-word loads
//   wdata_i  - right-justified store data
//   load_o   - addressed lane, shifted down and extended to 32 bits
//   store_o  - word_i with the addressed lane replaced by wdata_i low bits
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [4:0]  shift;
  logic [31:0] shifted;
  logic [31:0] mask;

  assign shift   = lane_shift(offset_i, size_i);
  assign shifted = word_i >> shift;

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path can leave it unassigned and infer a latch.
  always_comb begin
    load_o = word_i;
    mask   = 32'hFFFF_FFFF;
    case (size_i)
      SIZE_BYTE: begin
        load_o = {{24{~uns_i & shifted[7]}}, shifted[7:0]};
        mask   = 32'h0000_00FF << shift;
      end
      SIZE_HALF: begin
        load_o = {{16{~uns_i & shifted[15]}}, shifted[15:0]};
        mask   = 32'h0000_FFFF << shift;
      end
      default: ;
    endcase
  end

  assign store_o = (word_i & ~mask) | ((wdata_i << shift) & mask);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MIPS load/store initiator for port A of the data-cache RAM
// (1-cycle registered read, write-first q). One request in flight.
// Sub-word stores are done as read-modify-write; sub-word loads are
// extracted and sign/zero-extended. Big-endian lane order.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_ready - request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata - request fields
//   rsp_valid/rsp_ready - response handshake, response held until taken
//   rsp_rdata, rsp_err  - load result (0 for stores/errors), illegal flag
//   ram_addr, ram_data, ram_we, ram_q - RAM port A
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data,
  output logic                  ram_we,
  input  logic [31:0]           ram_q
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("dmem_access_ctrl supports DATA_WIDTH=32 only");
  end

  state_e                state_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;

  logic [31:0] load_val;
  logic [31:0] store_word;
  logic        word_store;

  // Address bits above the RAM range are deliberately dropped (aliasing).
  logic addr_hi_unused;
  assign addr_hi_unused = ^req_addr[31:ADDR_WIDTH+2];

  assign word_store = we_q && (size_q == SIZE_WORD);

  dmem_lane_align u_align (
    .word_i   (ram_q),
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .wdata_i  (wdata_q),
    .load_o   (load_val),
    .store_o  (store_word)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order of statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            addr_q      <= req_addr[ADDR_WIDTH+1:0];
            wdata_q     <= req_wdata;
            rsp_rdata_q <= '0;
            // Illegal requests skip the RAM entirely.
            if (is_illegal(req_size, req_addr[1:0])) begin
              rsp_err_q <= 1'b1;
              state_q   <= ST_RESP;
            end else begin
              rsp_err_q <= 1'b0;
              state_q   <= ST_RD;
            end
          end
        end
        ST_RD: begin
          state_q <= word_store ? ST_RESP : ST_MRG;
        end
        ST_MRG: begin
          if (!we_q) begin
            rsp_rdata_q <= load_val;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign ram_addr  = addr_q[ADDR_WIDTH+1:2];

  // RD: full-word write, or read for load/RMW. MRG: merged sub-word write.
  // Reset gates the strobe so an interrupted store never reaches the RAM.
  always_comb begin
    ram_we   = 1'b0;
    ram_data = wdata_q;
    case (state_q)
      ST_RD:  ram_we = word_store;
      ST_MRG: begin
        ram_we   = we_q;
        ram_data = store_word;
      end
      default: ;
    endcase
    if (rst) begin
      ram_we = 1'b0;
    end
  end

endmodule
